fetch_unit: RTL and testbench

Instruction-fetch stage that drives the word address into the instruction ROM (which registers the address and returns the instruction one cycle later) and presents fetched instructions to decode. Uses a valid/ready handshake toward decode. Keeps a PC, tags each returned word with its PC, and holds stalled words in a 2-entry skid buffer so no ROM data is lost. Accepts branch/jump redirects from downstream and squashes stale fetches.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Drives a word address into a registered instruction ROM, tags each returned
// word with its PC and hands it to decode over a valid/ready handshake. Words
// that decode cannot take yet are kept in a 2-entry skid buffer, so no ROM data
// is lost. A redirect flushes everything older and issues the target in the
// same cycle.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-redirect pulse on
// align_err). When it is undefined, align_err is tied to 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        align_err
);

    // Architectural state
    logic [31:0] pc_q,          pc_d;
    logic        inflight_q,    inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q,       count_d;
    logic [31:0] buf0_inst_q,   buf0_inst_d;
    logic [31:0] buf0_pc_q,     buf0_pc_d;
    logic [31:0] buf1_inst_q,   buf1_inst_d;
    logic [31:0] buf1_pc_q,     buf1_pc_d;

    logic        pop_s;
    logic        issue_en_s;
    logic [2:0]  occupancy_s;
    logic [31:0] redirect_word_s;

    // Word-aligned form of a byte address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Decode-side view: buffer head first, otherwise bypass the ROM return.
    always_comb begin
        if_valid = (count_q != 2'd0) | inflight_q;
        if (count_q != 2'd0) begin
            if_inst = buf0_inst_q;
            if_pc   = buf0_pc_q;
        end else if (inflight_q) begin
            if_inst = rom_inst;
            if_pc   = inflight_pc_q;
        end else begin
            if_inst = buf0_inst_q;
            if_pc   = buf0_pc_q;
        end
        pop_s = if_valid & if_ready;
        // Words still owned by this stage after this cycle's transfer.
        occupancy_s     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_en_s      = (occupancy_s < 3'd2);
        redirect_word_s = word_align(redirect_pc);
        // A redirect target goes to the ROM in the same cycle.
        if (redirect_valid) begin
            rom_addr = redirect_pc[31:2];
        end else begin
            rom_addr = pc_q[31:2];
        end
    end

    // Next-state: redirect flush, skid-buffer pop/push and issue decision.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        buf0_inst_d   = buf0_inst_q;
        buf0_pc_d     = buf0_pc_q;
        buf1_inst_d   = buf1_inst_q;
        buf1_pc_d     = buf1_pc_q;
        if (redirect_valid) begin
            // Everything older than the target is stale; a pop this cycle
            // still counts as delivered and decode flushes it itself.
            count_d       = 2'd0;
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_word_s;
            pc_d          = redirect_word_s + 32'd4;
        end else begin
            // Pop from the buffer head keeps strict PC order.
            if (pop_s && (count_q != 2'd0)) begin
                buf0_inst_d = buf1_inst_q;
                buf0_pc_d   = buf1_pc_q;
                count_d     = count_q - 2'd1;
            end else begin
                count_d     = count_q;
            end
            // Returned word not consumed by the bypass goes to the tail.
            if (inflight_q && !(pop_s && (count_q == 2'd0))) begin
                if (count_d == 2'd0) begin
                    buf0_inst_d = rom_inst;
                    buf0_pc_d   = inflight_pc_q;
                end else begin
                    buf1_inst_d = rom_inst;
                    buf1_pc_d   = inflight_pc_q;
                end
                count_d = count_d + 2'd1;
            end else begin
                count_d = count_d;
            end
            if (issue_en_s) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end else begin
                inflight_d    = 1'b0;
            end
        end
    end

    // State registers; async reset clears buffer contents so outputs read 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            count_q       <= 2'd0;
            buf0_inst_q   <= 32'h0000_0000;
            buf0_pc_q     <= 32'h0000_0000;
            buf1_inst_q   <= 32'h0000_0000;
            buf1_pc_q     <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            buf0_inst_q   <= buf0_inst_d;
            buf0_pc_q     <= buf0_pc_d;
            buf1_inst_q   <= buf1_inst_d;
            buf1_pc_q     <= buf1_pc_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_q;

    // One-cycle pulse in the cycle after a misaligned redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            align_q <= 1'b0;
        end else begin
            align_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
        end
    end

    assign align_err = align_q;
`else
    // Low redirect bits are dropped silently in this build.
    logic unused_redirect_lsb_s;
    assign unused_redirect_lsb_s = &{1'b0, redirect_pc[1:0]};
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a registered ROM model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [29:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        align_err;

    // Second instance: wrap-around reset PC, always ready, never redirected
    logic [29:0] b_rom_addr;
    logic [31:0] b_rom_inst;
    logic        b_if_valid;
    logic [31:0] b_if_inst;
    logic [31:0] b_if_pc;
    logic        b_align_err;
    logic        b_redirect_valid;
    logic [31:0] b_redirect_pc;
    logic        b_if_ready;

    int n_checks;
    int n_fail;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic ALN_EXP = 1'b1;
`else
    localparam logic ALN_EXP = 1'b0;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
        .if_pc(if_pc), .align_err(align_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(rst), .rom_addr(b_rom_addr), .rom_inst(b_rom_inst),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .if_valid(b_if_valid), .if_ready(b_if_ready), .if_inst(b_if_inst),
        .if_pc(b_if_pc), .align_err(b_align_err)
    );

    // Program image: a few fixed words, every other word is {2'b11, addr}.
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        case (a)
            30'h0000_0000: rom_word = 32'h3c1d1000;
            30'h0000_0001: rom_word = 32'h0c001403;
            30'h0000_0002: rom_word = 32'h37bd7000;
            30'h0000_0046: rom_word = 32'h27bdffd0;
            30'h0000_0047: rom_word = 32'hafbf002c;
            30'h0000_0058: rom_word = 32'h27bdfff0;
            default:       rom_word = {2'b11, a};
        endcase
    endfunction

    // Registered ROMs, reset by the inverse of the fetch reset.
    always_ff @(posedge clk or posedge (~rst)) begin
        if (~rst) begin
            rom_inst   <= 32'h0;
            b_rom_inst <= 32'h0;
        end else begin
            rom_inst   <= rom_word(rom_addr);
            b_rom_inst <= rom_word(b_rom_addr);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [29:0] e_addr;
        logic        e_align;
        logic        chk_b;
        logic        e_b_valid;
        logic [31:0] e_b_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ready, input logic rv, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                                input logic [29:0] eaddr, input logic ealign,
                                input logic chkb, input logic ebv, input logic [31:0] ebpc);
        vec_t v;
        v.ready = ready; v.rv = rv; v.rpc = rpc; v.e_valid = ev; v.e_pc = epc;
        v.e_inst = einst; v.e_addr = eaddr; v.e_align = ealign;
        v.chk_b = chkb; v.e_b_valid = ebv; v.e_b_pc = ebpc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        b_if_ready = 1'b1;
        b_redirect_valid = 1'b0;
        b_redirect_pc = 32'h0;

        //              rdy rv  rpc            v  pc            inst           addr           aln      chkb bv  bpc
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b0,32'h000,32'h00000000,30'h00,1'b0,    1'b1,1'b0,32'h0000_0000));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h000,32'h3c1d1000,30'h01,1'b0,    1'b1,1'b1,32'hFFFF_FFF8));
        vecs.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h004,32'h0c001403,30'h02,1'b0,    1'b1,1'b1,32'hFFFF_FFFC));
        vecs.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h004,32'h0c001403,30'h03,1'b0,    1'b1,1'b1,32'h0000_0000));
        vecs.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h004,32'h0c001403,30'h03,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h004,32'h0c001403,30'h03,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h004,32'h0c001403,30'h03,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h004,32'h0c001403,30'h03,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h008,32'h37bd7000,30'h04,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h00C,32'hC0000003,30'h05,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b1,32'h118,   1'b1,32'h010,32'hC0000004,30'h46,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h118,32'h27bdffd0,30'h47,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h11C,32'hafbf002c,30'h48,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b0,32'h0,     1'b1,32'h11C,32'hafbf002c,30'h49,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b0,1'b1,32'h160,   1'b1,32'h11C,32'hafbf002c,30'h58,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h160,32'h27bdfff0,30'h59,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b1,32'h11A,   1'b1,32'h164,32'hC0000059,30'h46,1'b0,    1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h118,32'h27bdffd0,30'h47,ALN_EXP, 1'b0,1'b0,32'h0));
        vecs.push_back(mk(1'b1,1'b0,32'h0,     1'b1,32'h11C,32'hafbf002c,30'h48,1'b0,    1'b0,1'b0,32'h0));

        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            if_ready       = vecs[i].ready;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk("if_valid",  i, {31'b0, if_valid},  {31'b0, vecs[i].e_valid});
            chk("if_pc",     i, if_pc,              vecs[i].e_pc);
            chk("if_inst",   i, if_inst,            vecs[i].e_inst);
            chk("rom_addr",  i, {2'b0, rom_addr},   {2'b0, vecs[i].e_addr});
            chk("align_err", i, {31'b0, align_err}, {31'b0, vecs[i].e_align});
            if (vecs[i].chk_b) begin
                chk("wrap_valid", i, {31'b0, b_if_valid}, {31'b0, vecs[i].e_b_valid});
                chk("wrap_pc",    i, b_if_pc,             vecs[i].e_b_pc);
            end
        end

        // Asynchronous reset in the middle of a clock phase clears everything.
        @(negedge clk);
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_valid", 100, {31'b0, if_valid}, 32'h0);
        chk("rst_pc",    100, if_pc,             32'h0);
        chk("rst_inst",  100, if_inst,           32'h0);
        chk("rst_addr",  100, {2'b0, rom_addr},  32'h0);
        chk("rst_align", 100, {31'b0, align_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_valid", 101, {31'b0, if_valid}, 32'h0);
        chk("rel_addr",  101, {2'b0, rom_addr},  32'h0);
        @(negedge clk);
        #1;
        chk("rel_valid", 102, {31'b0, if_valid}, 32'h1);
        chk("rel_pc",    102, if_pc,             32'h0);
        chk("rel_inst",  102, if_inst,           32'h3c1d1000);
        @(negedge clk);
        #1;
        chk("rel_pc",    103, if_pc,             32'h4);
        chk("rel_inst",  103, if_inst,           32'h0c001403);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
